// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its board-side neighbours:
// raw pushbuttons and the terminal-count flag in, count enable / clear / LEDs out.
interface stopwatch_ctrl_if;
    logic KEY_RUN;   // raw run/pause pushbutton, active-low
    logic KEY_CLR;   // raw clear pushbutton, active-low
    logic AT_MAX;    // counter chain currently shows 999
    logic TICK;      // one-cycle count enable to the counter chain
    logic CLR;       // one-cycle synchronous clear to the counter chain
    logic RUNNING;   // LED: stopwatch running
    logic HOLD;      // LED: stopped at terminal count

    // Board side: drives the keys and the terminal-count flag.
    modport master (
        output KEY_RUN, KEY_CLR, AT_MAX,
        input  TICK, CLR, RUNNING, HOLD
    );

    // Controller side.
    modport slave (
        input  KEY_RUN, KEY_CLR, AT_MAX,
        output TICK, CLR, RUNNING, HOLD
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: debounces the run and clear pushbuttons, runs the
// IDLE/RUN/PAUSE/DONE state machine, divides the system clock down to a
// one-cycle TICK per second and issues a one-cycle CLR to the counter chain.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 50000000,
    parameter int PS_W            = 26,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20,
    parameter int STOP_AT_MAX     = 1
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    stopwatch_ctrl_if.slave bus
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam bit              STOP    = (STOP_AT_MAX != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Key path: index 0 = run/pause, index 1 = clear
    // ------------------------------------------------------------------
    logic [1:0] raw_keys;
    logic [1:0] press;

    assign raw_keys = {bus.KEY_CLR, bus.KEY_RUN};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;    // debounced key level (1 = released)
            logic            level_d_reg;  // previous debounced level, for edge detect
            logic            pulse_reg;    // one-cycle press pulse
            logic [DB_W-1:0] db_cnt_reg;

            // Two-flop synchronizer, stability counter and registered press detect.
            always_ff @(posedge CLOCK_50 or posedge RESET) begin
                if (RESET) begin
                    sync1_reg   <= 1'b1;
                    sync2_reg   <= 1'b1;
                    level_reg   <= 1'b1;
                    level_d_reg <= 1'b1;
                    pulse_reg   <= 1'b0;
                    db_cnt_reg  <= '0;
                end else begin
                    sync1_reg   <= raw_keys[gi];
                    sync2_reg   <= sync1_reg;
                    level_d_reg <= level_reg;
                    // Only a debounced 1->0 transition counts as a press.
                    pulse_reg   <= level_d_reg & ~level_reg;
                    if (sync2_reg == level_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        level_reg  <= sync2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                end
            end

            assign press[gi] = pulse_reg;
        end
    endgenerate

    logic run_press;
    logic clr_press;

    assign run_press = press[0];
    assign clr_press = press[1];

    // ------------------------------------------------------------------
    // State machine and prescaler
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [PS_W-1:0] ps_reg, ps_next;
    logic            tick_reg, tick_next;
    logic            clr_reg, clr_next;
    logic            running_reg, running_next;
    logic            hold_reg, hold_next;
    logic            wrap;
    logic            stop_now;

    // A second boundary is reached only while counting in RUN.
    assign wrap     = (state_reg == RUN) && (ps_reg == PS_LAST);
    assign stop_now = wrap && bus.AT_MAX && STOP;

    // State, prescaler and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_reg   <= IDLE;
            ps_reg      <= '0;
            tick_reg    <= 1'b0;
            clr_reg     <= 1'b0;
            running_reg <= 1'b0;
            hold_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ps_reg      <= ps_next;
            tick_reg    <= tick_next;
            clr_reg     <= clr_next;
            running_reg <= running_next;
            hold_reg    <= hold_next;
        end
    end

    // Next state and prescaler; clear overrides everything, including run.
    always_comb begin
        state_next = state_reg;
        ps_next    = ps_reg;
        case (state_reg)
            IDLE: begin
                ps_next = '0;
                if (run_press) state_next = RUN;
            end
            RUN: begin
                // Count on every RUN cycle, including the one that pauses,
                // so a wrap coinciding with a pause still delivers its second.
                ps_next = wrap ? '0 : ps_reg + PS_W'(1);
                if (stop_now)       state_next = DONE;
                else if (run_press) state_next = PAUSE;
            end
            PAUSE: begin
                // Prescaler holds so the partial second resumes later.
                if (run_press) state_next = RUN;
            end
            DONE: begin
                ps_next = '0;
            end
            default: begin
                state_next = IDLE;
                ps_next    = '0;
            end
        endcase
        if (clr_press) begin
            state_next = IDLE;
            ps_next    = '0;
        end
    end

    // Output decode, registered one edge later so every output is a flop.
    always_comb begin
        tick_next    = wrap && !stop_now && !clr_press;
        clr_next     = clr_press;
        running_next = (state_reg == RUN);
        hold_next    = (state_reg == DONE);
    end

    assign bus.TICK    = tick_reg;
    assign bus.CLR     = clr_reg;
    assign bus.RUNNING = running_reg;
    assign bus.HOLD    = hold_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=5 and DEBOUNCE_CYCLES=4.
// Outputs are compared as {TICK, CLR, RUNNING, HOLD} at the falling edge.
module tb_stopwatch_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stopwatch_ctrl_if sw_if();

    stopwatch_ctrl #(
        .TICK_DIV        (5),
        .PS_W            (3),
        .DEBOUNCE_CYCLES (4),
        .DB_W            (2),
        .STOP_AT_MAX     (1)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       key_run;
        logic       key_clr;
        logic       at_max;
        logic [3:0] exp;   // {tick, clr, running, hold}
    } vec_t;

    vec_t vecs[45];

    function automatic logic [3:0] obs();
        return {sw_if.TICK, sw_if.CLR, sw_if.RUNNING, sw_if.HOLD};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got tick/clr/running/hold=%b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance one clock and compare the outputs.
    task automatic step_check(input string name, input logic [3:0] exp);
        @(negedge clk);
        check(name, obs(), exp);
    endtask

    // Wait for the next TICK (bounded) and compare the cycles it took.
    task automatic wait_tick(input string name, input int exp_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sw_if.TICK && n < 40);
        check_int(name, n, exp_cycles);
        $display("%s: TICK after %0d cycles (expected %0d)", name, n, exp_cycles);
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;

        // Table: 20 idle cycles, then KEY_RUN held low for 25 cycles.
        // Raw low first sampled on edge 1, press pulse after edge 7, RUN
        // entered on edge 8, RUNNING after edge 9, TICK after edges 13/18/23.
        for (int i = 0; i < 20; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 4'b0000};
        for (int j = 0; j < 25; j++) begin
            vecs[20 + j] = '{1'b0, 1'b1, 1'b0,
                             {(j == 12 || j == 17 || j == 22), 1'b0, (j >= 8), 1'b0}};
        end

        rst           = 1'b1;
        sw_if.KEY_RUN = 1'b1;
        sw_if.KEY_CLR = 1'b1;
        sw_if.AT_MAX  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", obs(), 4'b0000);
        $display("reset: outputs=%b", obs());
        rst = 1'b0;

        for (int i = 0; i < 45; i++) begin
            sw_if.KEY_RUN = vecs[i].key_run;
            sw_if.KEY_CLR = vecs[i].key_clr;
            sw_if.AT_MAX  = vecs[i].at_max;
            @(negedge clk);
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
            $display("vec %0d: run=%b clr=%b at_max=%b -> %b (expected %b)",
                     i, vecs[i].key_run, vecs[i].key_clr, vecs[i].at_max, obs(), vecs[i].exp);
        end

        // Still running with the key held: next wrap 3 cycles on.
        wait_tick("held_key_tick", 3);
        sw_if.KEY_RUN = 1'b1;
        wait_tick("period_tick", 5);

        // Pause with the prescaler at 2: key low 4 cycles after a TICK puts the
        // pause edge 12 cycles after that TICK, two cycles past the next wrap.
        repeat (4) @(negedge clk);
        sw_if.KEY_RUN = 1'b0;
        for (int k = 1; k <= 8; k++) step_check("pause_entry", {(k == 1 || k == 6), 1'b0, 1'b1, 1'b0});
        sw_if.KEY_RUN = 1'b1;
        for (int k = 9; k <= 58; k++) step_check("pause_hold", 4'b0000);
        $display("pause: held 50 cycles, outputs=%b", obs());

        // Resume: RUN re-entered on edge 8, remaining 3 counts give TICK on edge 11.
        sw_if.KEY_RUN = 1'b0;
        for (int m = 1; m <= 12; m++) step_check("resume", {(m == 11), 1'b0, (m >= 9), 1'b0});
        $display("resume: partial second completed, outputs=%b", obs());

        // Terminal count: wrap on edge 16 goes to DONE without TICK.
        sw_if.KEY_RUN = 1'b1;
        sw_if.AT_MAX  = 1'b1;
        for (int m = 13; m <= 28; m++) step_check("at_max", {1'b0, 1'b0, (m < 17), (m >= 17)});
        $display("at_max: HOLD=%b", sw_if.HOLD);

        // Run press in DONE is ignored.
        sw_if.KEY_RUN = 1'b0;
        for (int k = 0; k < 12; k++) step_check("done_run_ignored", 4'b0001);
        sw_if.KEY_RUN = 1'b1;
        sw_if.AT_MAX  = 1'b0;
        for (int k = 0; k < 8; k++) step_check("done_hold", 4'b0001);

        // Clear from DONE: CLR on edge 8 for one cycle, HOLD drops on edge 9.
        sw_if.KEY_CLR = 1'b0;
        for (int c = 1; c <= 10; c++) step_check("clear_done", {1'b0, (c == 8), 1'b0, (c < 9)});
        sw_if.KEY_CLR = 1'b1;
        for (int k = 0; k < 8; k++) step_check("after_clear", 4'b0000);
        $display("clear: back to idle, outputs=%b", obs());

        // Glitches of 3 cycles are shorter than the debounce window.
        for (int g = 0; g < 5; g++) begin
            sw_if.KEY_RUN = 1'b0;
            for (int k = 0; k < 3; k++) step_check("glitch_low", 4'b0000);
            sw_if.KEY_RUN = 1'b1;
            for (int k = 0; k < 3; k++) step_check("glitch_high", 4'b0000);
            $display("glitch %0d: outputs=%b", g, obs());
        end
        for (int k = 0; k < 10; k++) step_check("glitch_idle", 4'b0000);

        // Run, then simultaneous run+clear landing on a prescaler wrap.
        sw_if.KEY_RUN = 1'b0;
        wait_tick("first_tick_from_idle", 13);
        sw_if.KEY_RUN = 1'b1;
        for (int k = 1; k <= 7; k++) step_check("run_before_both", {(k == 5), 1'b0, 1'b1, 1'b0});
        sw_if.KEY_RUN = 1'b0;
        sw_if.KEY_CLR = 1'b0;
        for (int k = 1; k <= 12; k++) step_check("both_keys", {(k == 3), (k == 8), (k < 9), 1'b0});
        sw_if.KEY_RUN = 1'b1;
        sw_if.KEY_CLR = 1'b1;
        for (int k = 0; k < 10; k++) step_check("both_release", 4'b0000);
        $display("run+clear: clear won, outputs=%b", obs());

        // Reset in the middle of a second (prescaler at 3).
        sw_if.KEY_RUN = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step_check("run_before_reset", {1'b0, 1'b0, (k >= 9), 1'b0});
            if (k == 8) sw_if.KEY_RUN = 1'b1;
        end
        rst = 1'b1;
        #1;
        check("reset_async", obs(), 4'b0000);
        $display("mid-run reset: outputs=%b", obs());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step_check("after_reset", 4'b0000);

        // Fresh run after reset: full 5 cycles to the first TICK.
        sw_if.KEY_RUN = 1'b0;
        for (int m = 1; m <= 15; m++) step_check("run_after_reset", {(m == 13), 1'b0, (m >= 9), 1'b0});
        $display("post-reset run: outputs=%b", obs());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control stage directly upstream of the cascaded mod-10 seconds counter chain and its HEX display.
- Debounces two raw active-low pushbuttons: run/pause and clear.
- Runs a run/pause/done state machine.
- Divides CLOCK_50 into a one-cycle TICK enable that advances the counter chain once per second.
- Issues a one-cycle CLR to the chain and stops at terminal count (999) instead of wrapping.

Parameters:
TICK_DIV, 50000000, CLOCK_50 cycles per TICK (1 Hz at 50 MHz); legal range ≥ 2
PS_W, 26, prescaler width; must satisfy 2^PS_W ≥ TICK_DIV
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key change (20 ms); legal range ≥ 1
DB_W, 20, debounce counter width; must satisfy 2^DB_W ≥ DEBOUNCE_CYCLES
STOP_AT_MAX, 1, 1: freeze in DONE at terminal count; 0: let the chain wrap

Ports:
CLOCK_50  input   1  system clock
RESET     input   1  asynchronous, active-high reset
KEY_RUN   input   1  raw pushbutton, active-low, asynchronous; press toggles run/pause
KEY_CLR   input   1  raw pushbutton, active-low, asynchronous; press clears
AT_MAX    input   1  from counter chain; high while the count equals 999
TICK      output  1  one-cycle count enable to the counter chain
CLR       output  1  one-cycle synchronous clear to the counter chain
RUNNING   output  1  high in RUN (LED)
HOLD      output  1  high in DONE (LED)

Behaviour:
Reset
- RESET high asynchronously forces:
  - state = IDLE
  - prescaler = 0
  - both debounce counters = 0
  - both sync flops and debounced levels = 1 (released)
  - TICK, CLR, RUNNING, HOLD = 0
- Reset mid-count discards the partial second. No press pulse is generated coming out of reset.

Key path (identical for each key)
- Sync: 2-flop synchronizer on the raw key.
- Debounce counter:
  - If synchronized level ≠ debounced level: counter increments each cycle.
  - If the levels are equal on any cycle: counter clears to 0.
  - On the edge where counter = DEBOUNCE_CYCLES-1 and the levels still differ: debounced level takes the synchronized level and counter clears.
- Press pulse: registered, high for exactly one cycle on each debounced 1→0 transition. Release produces no pulse.
- Latency: press pulse is high DEBOUNCE_CYCLES+3 rising edges after the first edge that samples raw low.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no pulse.

State machine (transitions on the edge where the press pulse is high)
- IDLE: prescaler held at 0; no TICK. run press → RUN.
- RUN:
  - Prescaler increments; on the edge where it equals TICK_DIV-1 it returns to 0.
    - If AT_MAX=1 and STOP_AT_MAX=1: → DONE, no TICK.
    - Otherwise: TICK=1 for the following cycle.
  - run press → PAUSE.
- PAUSE: prescaler holds its value, so the partial second resumes. run press → RUN.
- DONE: prescaler held at 0; run press ignored.
- Clear (any state): clear press → IDLE, prescaler = 0, CLR=1 for the following cycle.
- Clear press and run press in the same cycle: clear wins; run is discarded.
- A prescaler wrap on the same edge as a run press (RUN→PAUSE) still issues that TICK.
- A wrap on the same edge as a clear press issues no TICK.

Outputs
- All outputs are registered; TICK and CLR are never high together.
- RUNNING = (state==RUN); HOLD = (state==DONE). Both update one edge after the transition.
- First TICK after IDLE→RUN arrives TICK_DIV edges after entering RUN.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=5, DEBOUNCE_CYCLES=4.
1. Release RESET, hold keys high 20 cycles → TICK, CLR, RUNNING, HOLD all 0; no press pulses.
2. Drive KEY_RUN low permanently → press pulse 7 edges after first low sample; RUNNING=1 next cycle; TICK pulses every 5 cycles, width 1; exactly one pulse despite the held key.
3. KEY_RUN low for 3 cycles then high, repeated ×5 → no press pulse; state remains IDLE.
4. RUN with prescaler=2, press run → PAUSE, prescaler holds 2 for 50 cycles, no TICK; press run again → next TICK arrives 3 edges after re-entering RUN.
5. RUN with AT_MAX=1 at prescaler wrap → no TICK; HOLD=1; a further run press leaves HOLD=1; clear press → CLR one cycle, HOLD=0, state IDLE.
6. Debounced run and clear presses in the same cycle from RUN → state IDLE, CLR=1 once, RUNNING=0. Assert RESET mid-RUN with prescaler=3 → all outputs 0 immediately; after release, first TICK follows a new run press by the full 5 cycles.
